// File: rtl/tpu_pkg.sv
// Purpose: shared TPU types and constants (array geometry, sequencer states, opcodes).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tpu_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ARRAY_DIM  = 4;

    // Matrix-multiply sequencer phases
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Decoder opcodes; the sequencer only reacts to the start/abort pulses they produce
    localparam logic [1:0] START = 2'd0;
    localparam logic [1:0] STOP  = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;
    localparam logic [1:0] STORE = 2'd3;

endpackage

// File: rtl/skew_decoder.sv
// Purpose: maps the FEED phase counter onto per-lane diagonal-wavefront read enables and element indices.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow cnt/feed directly.
module skew_decoder #(
    parameter int N     = 4,
    parameter int CNT_W = 4,
    parameter int LW    = 2
) (
    input  logic [CNT_W-1:0]  cnt,
    input  logic              feed,
    output logic [N-1:0]      rd_en,
    output logic [N*LW-1:0]   rd_elem
);

    // Lane i is live for cnt in [i, i+N-1] and reads element cnt-i; idle lanes present index 0
    always_comb begin
        rd_en   = '0;
        rd_elem = '0;
        for (int i = 0; i < N; i++) begin
            if (feed && (int'(cnt) >= i) && (int'(cnt) <= i + N - 1)) begin
                rd_en[i]             = 1'b1;
                rd_elem[i*LW +: LW]  = LW'(int'(cnt) - i);
            end
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Purpose: sequences one N x N systolic multiply: clear, skewed operand feed, drain, done pulse.
//          Optional MATMUL_SEQUENCER_PERF_EN adds saturating run_count / abort_count outputs.
// Latency: start sampled at edge 0 -> busy in cycle 1; busy for 1+(2N-1)+DRAIN_CYCLES+1 cycles.
// Backpressure: none; start while busy is dropped, abort outside IDLE returns to IDLE next cycle.
module matmul_sequencer
    import tpu_pkg::*;
#(
    parameter int N            = 4,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 4,
    localparam int LW          = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              array_clear,
    output logic              array_enable,
    output logic [N-1:0]      rd_en,
    output logic [N*LW-1:0]   rd_elem
`ifdef MATMUL_SEQUENCER_PERF_EN
    ,
    output logic [15:0]       run_count,
    output logic [7:0]        abort_count
`endif
);

    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(2*N - 2);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Phase FSM; cnt is cleared on every transition so it never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start && !abort) state <= CLEAR;
                end
                CLEAR: begin
                    cnt   <= '0;
                    state <= abort ? IDLE : FEED;
                end
                FEED: begin
                    if (abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == FEED_LAST) begin
                        state <= DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DRAIN_LAST) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    // done is already high this cycle, so abort changes nothing here
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Moore decode of registered state; reset drops these asynchronously via state
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign array_clear  = (state == CLEAR);
    assign array_enable = (state == FEED) || (state == DRAIN);

    skew_decoder #(
        .N     (N),
        .CNT_W (CNT_W),
        .LW    (LW)
    ) u_skew (
        .cnt     (cnt),
        .feed    (state == FEED),
        .rd_en   (rd_en),
        .rd_elem (rd_elem)
    );

`ifdef MATMUL_SEQUENCER_PERF_EN
    // Saturating completion and abort counters, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_count   <= '0;
            abort_count <= '0;
        end else begin
            if (state == DONE && run_count != 16'hFFFF)
                run_count <= run_count + 16'd1;
            if (abort && state != IDLE && abort_count != 8'hFF)
                abort_count <= abort_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
module tb_matmul_sequencer;
    import tpu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       array_clear;
    logic       array_enable;
    logic [3:0] rd_en;
    logic [7:0] rd_elem;
`ifdef MATMUL_SEQUENCER_PERF_EN
    logic [15:0] run_count;
    logic [7:0]  abort_count;
`endif

    int errors = 0;
    int checks = 0;

    // expected output vector {busy, done, array_clear, array_enable, rd_en[3:0], rd_elem[7:0]}
    logic [15:0] exp_q [$];
    logic [15:0] trace [0:14];

    matmul_sequencer #(
        .N            (4),
        .DRAIN_CYCLES (4),
        .CNT_W        (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .array_clear  (array_clear),
        .array_enable (array_enable),
        .rd_en        (rd_en),
        .rd_elem      (rd_elem)
`ifdef MATMUL_SEQUENCER_PERF_EN
        ,
        .run_count    (run_count),
        .abort_count  (abort_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every negedge with an expectation pending, compare the whole output vector
    always @(negedge clk) begin
        logic [15:0] act;
        logic [15:0] e;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {busy, done, array_clear, array_enable, rd_en, rd_elem};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL outputs @%0t: got busy=%b done=%b clr=%b en=%b rd_en=%b rd_elem=%h, expected busy=%b done=%b clr=%b en=%b rd_en=%b rd_elem=%h",
                         $time, act[15], act[14], act[13], act[12], act[11:8], act[7:0],
                         e[15], e[14], e[13], e[12], e[11:8], e[7:0]);
            end
        end
    end

    // Drive inputs for one cycle; e is what the DUT must show in the cycle after the edge
    task automatic cyc(input logic s, input logic a, input logic [15:0] e);
        start = s;
        abort = a;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        exp_q.push_back(e);
    endtask

    // One full multiply from a start pulse; dup = cycle carrying a spurious start (0 = none)
    task automatic run_full(input int dup, input logic abort_in_done);
        cyc(1'b1, 1'b0, trace[1]);
        for (int k = 2; k <= 13; k++)
            cyc(logic'((k - 1) == dup), 1'b0, trace[k]);
        cyc(1'b0, abort_in_done, trace[14]);
    endtask

    initial begin
        // Hand-derived N=4 trace, index = cycle number after the start edge
        trace[0]  = 16'h0000;
        trace[1]  = 16'hA000;                      // CLEAR
        trace[2]  = 16'h9100;                      // FEED cnt0: lane0 elem0
        trace[3]  = 16'h9301;                      // cnt1: l0=1 l1=0
        trace[4]  = 16'h9706;                      // cnt2: l0=2 l1=1 l2=0
        trace[5]  = 16'h9F1B;                      // cnt3: 3,2,1,0
        trace[6]  = 16'h9E6C;                      // cnt4: l1=3 l2=2 l3=1
        trace[7]  = 16'h9CB0;                      // cnt5: l2=3 l3=2
        trace[8]  = 16'h98C0;                      // cnt6: l3=3
        trace[9]  = 16'h9000;                      // DRAIN x4
        trace[10] = 16'h9000;
        trace[11] = 16'h9000;
        trace[12] = 16'h9000;
        trace[13] = 16'hC000;                      // DONE
        trace[14] = 16'h0000;                      // back to IDLE

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(16'h0000);                 // reset state
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 16'h0000);

        // Plain run
        run_full(0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000);

        // Start again in cycle 6 while busy: ignored
        run_full(6, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000);

        // Abort in cycle 5 (FEED), then a fresh start in cycle 8
        cyc(1'b1, 1'b0, trace[1]);
        for (int k = 2; k <= 5; k++) cyc(1'b0, 1'b0, trace[k]);
        cyc(1'b0, 1'b1, 16'h0000);                 // cycle 6
        cyc(1'b0, 1'b0, 16'h0000);                 // cycle 7
        run_full(0, 1'b0);                         // start in cycle 8
        cyc(1'b0, 1'b0, 16'h0000);

        // Abort while in CLEAR
        cyc(1'b1, 1'b0, trace[1]);
        cyc(1'b0, 1'b1, 16'h0000);
        cyc(1'b0, 1'b0, 16'h0000);

        // Abort in DRAIN
        cyc(1'b1, 1'b0, trace[1]);
        for (int k = 2; k <= 10; k++) cyc(1'b0, 1'b0, trace[k]);
        cyc(1'b0, 1'b1, 16'h0000);
        cyc(1'b0, 1'b0, 16'h0000);

        // Abort in the DONE cycle: done already shown, normal return to IDLE
        run_full(0, 1'b1);

        // start and abort together in IDLE, and lone abort in IDLE
        cyc(1'b1, 1'b1, 16'h0000);
        cyc(1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b1, 16'h0000);
        cyc(1'b0, 1'b0, 16'h0000);

`ifdef MATMUL_SEQUENCER_PERF_EN
        // 4 completed runs, aborts in FEED, CLEAR, DRAIN and DONE
        checks++;
        if (run_count !== 16'd4) begin
            errors++;
            $display("FAIL run_count: got %0d expected 4", run_count);
        end
        checks++;
        if (abort_count !== 8'd4) begin
            errors++;
            $display("FAIL abort_count: got %0d expected 4", abort_count);
        end
`endif

        // Reset asserted in cycle 7 of a run: outputs must drop before any edge
        cyc(1'b1, 1'b0, trace[1]);
        for (int k = 2; k <= 6; k++) cyc(1'b0, 1'b0, trace[k]);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.push_back(16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 16'h0000);

        // Clean run after reset
        run_full(0, 1'b0);

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a hung bench
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
